// File: rtl/dcache_pkg.sv
// Shared parameters, FSM encoding and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W   = 15;
    localparam int TAG_W    = 5;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 256;
    localparam int WORDS    = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_WAIT,
        FILL,
        RESP
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Address of word 0 of the block that holds a.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read by index, single-cycle whole-line write.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INDEX_W-1:0]            i_rd_index,
    output logic                          o_rd_valid,
    output logic [TAG_W-1:0]              o_rd_tag,
    output logic [WORDS-1:0][DATA_W-1:0]  o_rd_data,
    input  logic                          i_wr_en,
    input  logic [INDEX_W-1:0]            i_wr_index,
    input  logic [TAG_W-1:0]              i_wr_tag,
    input  logic [WORDS-1:0][DATA_W-1:0]  i_wr_block
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];

    // Only the valid bits are cleared; tag and data contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_bank
            logic [DATA_W-1:0] r_bank [LINES];

            always_ff @(posedge clk) begin
                if (i_wr_en) begin
                    r_bank[i_wr_index] <= i_wr_block[gi];
                end
            end

            assign o_rd_data[gi] = r_bank[i_rd_index];
        end
    endgenerate

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped read cache controller: hit in two cycles, block fill from main memory on a miss.
module dcache_controller #(
    parameter int ADDR_W      = 15,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_w0,
    input  logic [31:0]       mem_w1,
    input  logic [31:0]       mem_w2,
    input  logic [31:0]       mem_w3,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  access_count
);
    import dcache_pkg::*;

    localparam int WAIT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t                       r_state;
    logic [ADDR_W-1:0]            r_req_addr;
    logic [ADDR_W-1:0]            r_mem_addr;
    logic [WAIT_W-1:0]            r_wait;
    logic                         r_req_ready;
    logic                         r_rsp_valid;
    logic                         r_rsp_hit;
    logic [31:0]                  r_rsp_data;
    logic [CNT_W-1:0]             r_hit_count;
    logic [CNT_W-1:0]             r_access_count;

    logic [INDEX_W-1:0]           w_index;
    logic [OFFSET_W-1:0]          w_offset;
    logic                         w_rd_valid;
    logic [TAG_W-1:0]             w_rd_tag;
    logic [WORDS-1:0][DATA_W-1:0] w_rd_data;
    logic [WORDS-1:0][DATA_W-1:0] w_mem_block;
    logic                         w_hit;
    logic                         w_wr_en;

    assign w_index     = addr_index(r_req_addr);
    assign w_offset    = addr_offset(r_req_addr);
    assign w_mem_block = {mem_w3, mem_w2, mem_w1, mem_w0};
    assign w_hit       = w_rd_valid && (w_rd_tag == addr_tag(r_req_addr));
    // A reset landing on the FILL edge must not leave a half-committed line behind.
    assign w_wr_en     = (r_state == FILL) && !rst;

    dcache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_index),
        .i_wr_tag   (addr_tag(r_req_addr)),
        .i_wr_block (w_mem_block)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_req_addr     <= '0;
            r_mem_addr     <= '0;
            r_wait         <= '0;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_hit      <= 1'b0;
            r_rsp_data     <= '0;
            r_hit_count    <= '0;
            r_access_count <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_addr  <= req_addr;
                        r_req_ready <= 1'b0;
                        r_state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (r_access_count != CNT_MAX) begin
                        r_access_count <= r_access_count + CNT_ONE;
                    end
                    if (w_hit) begin
                        r_rsp_data  <= w_rd_data[w_offset];
                        r_rsp_hit   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        if (r_hit_count != CNT_MAX) begin
                            r_hit_count <= r_hit_count + CNT_ONE;
                        end
                        r_state <= RESP;
                    end else begin
                        r_mem_addr <= block_addr(r_req_addr);
                        r_wait     <= WAIT_LOAD;
                        r_state    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= FILL;
                    end else begin
                        r_wait <= r_wait - WAIT_ONE;
                    end
                end
                FILL: begin
                    r_rsp_data  <= w_mem_block[w_offset];
                    r_rsp_hit   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_hit      = r_rsp_hit;
    assign mem_addr     = r_mem_addr;
    assign hit_count    = r_hit_count;
    assign access_count = r_access_count;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller; memory word at address a holds value a.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic [14:0] req_addr  = '0;
    logic        req_ready, rsp_valid, rsp_hit;
    logic [31:0] rsp_data;
    logic [14:0] mem_addr;
    logic [31:0] mem_w0, mem_w1, mem_w2, mem_w3;
    logic [15:0] hit_count, access_count;

    logic        s_req_valid = 1'b0;
    logic [14:0] s_req_addr  = '0;
    logic        s_req_ready, s_rsp_valid, s_rsp_hit;
    logic [31:0] s_rsp_data;
    logic [14:0] s_mem_addr;
    logic [31:0] s_mem_w0, s_mem_w1, s_mem_w2, s_mem_w3;
    logic [3:0]  s_hit_count, s_access_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_w0 = {17'd0, mem_addr};
    assign mem_w1 = {17'd0, mem_addr + 15'd1};
    assign mem_w2 = {17'd0, mem_addr + 15'd2};
    assign mem_w3 = {17'd0, mem_addr + 15'd3};
    assign s_mem_w0 = {17'd0, s_mem_addr};
    assign s_mem_w1 = {17'd0, s_mem_addr + 15'd1};
    assign s_mem_w2 = {17'd0, s_mem_addr + 15'd2};
    assign s_mem_w3 = {17'd0, s_mem_addr + 15'd3};

    dcache_controller #(.ADDR_W(15), .MEM_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .mem_addr(mem_addr),
        .mem_w0(mem_w0), .mem_w1(mem_w1), .mem_w2(mem_w2), .mem_w3(mem_w3),
        .hit_count(hit_count), .access_count(access_count)
    );

    dcache_controller #(.ADDR_W(15), .MEM_LATENCY(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_hit(s_rsp_hit),
        .mem_addr(s_mem_addr),
        .mem_w0(s_mem_w0), .mem_w1(s_mem_w1), .mem_w2(s_mem_w2), .mem_w3(s_mem_w3),
        .hit_count(s_hit_count), .access_count(s_access_count)
    );

    // One read on either instance; lat counts edges from accept to the edge where rsp_valid is seen.
    task automatic do_read(input bit sel, input logic [14:0] a, output logic [31:0] d,
                           output logic h, output int lat, output logic [14:0] ma);
        bit rdy;
        d = '0; h = 1'b0; lat = -1; ma = '0; rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = sel ? s_req_ready : req_ready;
            if (rdy) break;
        end
        if (!rdy) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: addr=%h req_ready stayed 0, required 1", a);
            return;
        end
        if (sel) begin s_req_valid = 1'b1; s_req_addr = a; end
        else     begin req_valid = 1'b1;   req_addr = a;   end
        @(posedge clk);
        #1;
        if (sel) s_req_valid = 1'b0; else req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) ma = sel ? s_mem_addr : mem_addr;
            if (sel ? s_rsp_valid : rsp_valid) begin
                lat = k;
                d = sel ? s_rsp_data : rsp_data;
                h = sel ? s_rsp_hit : rsp_hit;
                $display("read inst=%0d addr=%h data=%h hit=%b lat=%0d", sel, a, d, h, lat);
                return;
            end
        end
        n_cmp++; n_err++;
        $display("FAIL rsp_timeout: addr=%h no rsp_valid within 40 cycles, required a response", a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
        n_cmp++; if (rsp_hit !== 1'b0) begin n_err++; $display("FAIL rst_rsp_hit: got %b expected 0", rsp_hit); end
        n_cmp++; if (mem_addr !== 15'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (hit_count !== 16'd0 || access_count !== 16'd0) begin
            n_err++; $display("FAIL rst_counters: got hit=%0d acc=%0d expected 0/0", hit_count, access_count); end
        n_cmp++; if (s_hit_count !== 4'd0 || s_access_count !== 4'd0) begin
            n_err++; $display("FAIL rst_sat_counters: got hit=%0d acc=%0d expected 0/0", s_hit_count, s_access_count); end
        $display("reset released");
    endtask

    task automatic test_miss_then_hit();
        logic [31:0] d; logic h; int lat; logic [14:0] ma;
        do_read(1'b0, 15'h0005, d, h, lat, ma);
        n_cmp++; if (ma !== 15'h0004) begin n_err++; $display("FAIL miss_mem_addr: got %h expected 0004", ma); end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL miss_latency: got %0d expected 7", lat); end
        n_cmp++; if (d !== 32'h5) begin n_err++; $display("FAIL miss_data: got %h expected 5", d); end
        n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL miss_hit: got %b expected 0", h); end
        n_cmp++; if (access_count !== 16'd1 || hit_count !== 16'd0) begin
            n_err++; $display("FAIL miss_counters: got acc=%0d hit=%0d expected 1/0", access_count, hit_count); end
        do_read(1'b0, 15'h0007, d, h, lat, ma);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d expected 2", lat); end
        n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL hit_data: got %h expected 7", d); end
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL hit_flag: got %b expected 1", h); end
        n_cmp++; if (access_count !== 16'd2 || hit_count !== 16'd1) begin
            n_err++; $display("FAIL hit_counters: got acc=%0d hit=%0d expected 2/1", access_count, hit_count); end
    endtask

    task automatic test_conflict();
        logic [31:0] d; logic h; int lat; logic [14:0] ma;
        do_read(1'b0, 15'h0405, d, h, lat, ma);
        n_cmp++; if (h !== 1'b0 || d !== 32'h405) begin
            n_err++; $display("FAIL conflict_first: got hit=%b data=%h expected 0/405", h, d); end
        n_cmp++; if (ma !== 15'h0404) begin n_err++; $display("FAIL conflict_mem_addr: got %h expected 0404", ma); end
        do_read(1'b0, 15'h0005, d, h, lat, ma);
        n_cmp++; if (h !== 1'b0 || d !== 32'h5) begin
            n_err++; $display("FAIL conflict_evicted: got hit=%b data=%h expected 0/5", h, d); end
        n_cmp++; if (access_count !== 16'd4 || hit_count !== 16'd1) begin
            n_err++; $display("FAIL conflict_counters: got acc=%0d hit=%0d expected 4/1", access_count, hit_count); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] addrs [5];
        logic        hits  [5];
        int npulse = 0; int busy = 0; int bad_ready = 0;
        addrs = '{15'h006, 15'h405, 15'h404, 15'h010, 15'h011};
        hits  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    req_addr  = addrs[i];
                    req_valid = 1'b1;
                    for (int w = 0; w < 30; w++) begin
                        @(negedge clk);
                        if (req_ready) break;
                    end
                    @(posedge clk);
                    #1;
                end
                req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(negedge clk);
                    if (req_valid && !req_ready) busy++;
                    if (rsp_valid) begin
                        if (req_ready) bad_ready++;
                        if (npulse < 5) begin
                            $display("stream rsp %0d data=%h hit=%b", npulse, rsp_data, rsp_hit);
                            n_cmp++;
                            if (rsp_data !== {17'd0, addrs[npulse]} || rsp_hit !== hits[npulse]) begin
                                n_err++;
                                $display("FAIL stream_rsp%0d: got data=%h hit=%b expected data=%h hit=%b",
                                         npulse, rsp_data, rsp_hit, addrs[npulse], hits[npulse]);
                            end
                        end
                        npulse++;
                    end
                end
            end
        join
        n_cmp++; if (npulse !== 5) begin n_err++; $display("FAIL stream_count: got %0d pulses expected 5", npulse); end
        n_cmp++; if (busy == 0) begin n_err++; $display("FAIL stream_busy: got %0d busy cycles expected >0", busy); end
        n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL stream_ready_in_resp: got %0d expected 0", bad_ready); end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] d; logic h; int lat; logic [14:0] ma; int pulses = 0;
        @(negedge clk);
        req_addr = 15'h0123; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset mid-miss applied");
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
        n_cmp++; if (access_count !== 16'd0 || hit_count !== 16'd0) begin
            n_err++; $display("FAIL midrst_counters: got acc=%0d hit=%0d expected 0/0", access_count, hit_count); end
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_rsp: got %0d pulses expected 0", pulses); end
        do_read(1'b0, 15'h0123, d, h, lat, ma);
        n_cmp++; if (h !== 1'b0 || d !== 32'h123 || lat !== 7) begin
            n_err++; $display("FAIL midrst_reread: got hit=%b data=%h lat=%0d expected 0/123/7", h, d, lat); end
    endtask

    task automatic test_reset_vs_request();
        int pulses = 0;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_addr = 15'h0123;
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        $display("reset with concurrent request applied");
        n_cmp++; if (req_ready !== 1'b1 || access_count !== 16'd0) begin
            n_err++; $display("FAIL rstreq_not_accepted: got ready=%b acc=%0d expected 1/0", req_ready, access_count); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rstreq_no_rsp: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic h; int lat; logic [14:0] ma; int nhits = 0; logic [14:0] a;
        do_read(1'b1, 15'h0020, d, h, lat, ma);
        n_cmp++; if (h !== 1'b0 || d !== 32'h20) begin
            n_err++; $display("FAIL sat_fill: got hit=%b data=%h expected 0/20", h, d); end
        for (int i = 0; i < 20; i++) begin
            a = 15'h0020 + 15'(i % 4);
            do_read(1'b1, a, d, h, lat, ma);
            if (h === 1'b1 && d === {17'd0, a}) nhits++;
        end
        n_cmp++; if (nhits !== 20) begin n_err++; $display("FAIL sat_hits_ok: got %0d correct hits expected 20", nhits); end
        n_cmp++; if (s_hit_count !== 4'd15) begin n_err++; $display("FAIL sat_hit_count: got %0d expected 15", s_hit_count); end
        n_cmp++; if (s_access_count !== 4'd15) begin n_err++; $display("FAIL sat_access_count: got %0d expected 15", s_access_count); end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_back_to_back();
        test_reset_mid_miss();
        test_reset_vs_request();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped data cache controller for the 15-bit word-addressed main memory. It accepts single-word read requests and answers hits from an internal 256-line × 4-word array. On a miss it sequences a block fetch from the main-memory block port, fills the line and then responds. It sits between the CPU load path and the main memory, and keeps hit and access statistics.

## Interface
- ADDR_W, 15, word address width (tag 5 = addr[14:10], index 8 = addr[9:2], offset 2 = addr[1:0])
- MEM_LATENCY, 4, cycles main memory needs before its block words are valid; must be ≥1
- CNT_W, 16, width of the statistics counters

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  read request present
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_W  word address of the request
- rsp_valid  out  1  one-cycle pulse: rsp_data and rsp_hit are valid
- rsp_data  out  32  requested word
- rsp_hit  out  1  1 = served from cache, 0 = served after a fill
- mem_addr  out  ADDR_W  block-aligned address driven to main memory
- mem_w0..mem_w3  in  32 each  block words at offsets 0..3 of mem_addr
- hit_count  out  CNT_W  saturating hit counter
- access_count  out  CNT_W  saturating access counter

## Operation
- FSM states: IDLE, COMPARE, MEM_WAIT, FILL, RESP.
- IDLE:
  - req_ready = 1; in every other state req_ready = 0.
  - A request is accepted when req_valid && req_ready at a clock edge. The controller latches req_addr and moves to COMPARE.
- COMPARE:
  - Reads valid[index], tag[index] and data[index][offset], and increments access_count.
  - Hit (valid && tag match): latch the word into rsp_data, set rsp_hit = 1, increment hit_count, go to RESP.
  - Miss: load mem_addr = {tag, index, 2'b00}, load the wait counter with MEM_LATENCY−1, go to MEM_WAIT.
- MEM_WAIT: decrement the counter each cycle. When it reads 0, go to FILL.
- FILL:
  - Write mem_w0..mem_w3 into data[index][0..3], write tag[index], set valid[index] = 1.
  - Latch the word mem_w[offset] into rsp_data, set rsp_hit = 0, go to RESP.
- RESP: rsp_valid = 1 for this single cycle, then go to IDLE. There is no response back-pressure.
- mem_addr is registered and holds its value outside MEM_WAIT/FILL.
- Counters saturate at all-ones and never wrap.
- Only one request is ever in flight. A request arriving while req_ready = 0 is not accepted; the requester must hold it.
- Tag and data arrays are not reset. Only the valid bits are reset.

## Timing
- Accept edge = E0.
- Hit: COMPARE during E0→E1; rsp_valid high E1→E2. Hit latency is 2 cycles (response sampled at E2). req_ready is high again from E2.
- Miss: COMPARE E0→E1; MEM_WAIT for exactly MEM_LATENCY cycles (E1→E(1+L)); FILL E(1+L)→E(2+L); rsp_valid high E(2+L)→E(3+L). Miss latency is 3+MEM_LATENCY cycles.
- mem_addr is stable from E1 until the end of FILL.
- Minimum spacing between accepts: 3 cycles for back-to-back hits.
- Reset values: state IDLE, req_ready 1 in the cycle after reset, rsp_valid 0, rsp_data 0, rsp_hit 0, mem_addr 0, hit_count 0, access_count 0, all valid bits 0.
- Reset in any state, including mid-miss: return to IDLE on the next edge. No fill occurs, no rsp_valid pulse, and counters are cleared.
- If req_valid and rst are both high at the same edge, reset wins and the request is not accepted.

## Structure
- Shared package dcache_pkg holds:
  - ADDR_W, TAG_W = 5, INDEX_W = 8, OFFSET_W = 2, LINES = 256
  - the FSM state encoding
  - address-field slice helpers
- Sub-module dcache_array holds valid/tag/data storage:
  - combinational read by index
  - one-cycle 4-word block write with tag
  - synchronous clear of all valid bits on rst
- dcache_controller holds the FSM, the wait counter, the mem_addr and response registers, and the statistics counters.

## Test plan
Memory model: word at address a holds value a. MEM_LATENCY = 4.
- Reset, then read 0x0005 → mem_addr = 0x0004 during MEM_WAIT; rsp_valid 7 cycles after accept; rsp_data = 0x5, rsp_hit = 0; access_count = 1, hit_count = 0.
- Then read 0x0007 → rsp_hit = 1, rsp_data = 0x7, response 2 cycles after accept; hit_count = 1, access_count = 2.
- Conflict on index 1: read 0x0405 → miss, rsp_data = 0x405. Then read 0x0005 → miss again, rsp_data = 0x5 (line evicted).
- req_valid held high with a stream of 5 addresses → req_ready is low outside IDLE, and exactly 5 rsp_valid pulses arrive in order with matching data.
- Assert rst during the 2nd MEM_WAIT cycle of a miss → IDLE next cycle, no rsp_valid pulse, counters 0. A re-read of the same address is a miss.
- With CNT_W = 4: 1 fill plus 20 hits to the same line → hit_count = 15, access_count = 15 (both saturated).
